// File: rtl/kanagawa_fifo_show_ahead_reader_if.sv
// Interface bundle for kanagawa_fifo_show_ahead_reader.
// It carries the tracker-side write/read signals and the show-ahead consumer stream.
// master: the tracker and consumer side. slave: the reader block.
interface kanagawa_fifo_show_ahead_reader_if #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 5,
  parameter int OCC_W     = 2
);
  logic                 wren_in;
  logic [LOG_DEPTH-1:0] wrptr_in;
  logic [WIDTH-1:0]     wrdata_in;
  logic                 empty_in;
  logic [LOG_DEPTH-1:0] rdptr_in;
  logic                 rdreq_out;
  logic                 valid_out;
  logic [WIDTH-1:0]     data_out;
  logic                 ready_in;
  logic [OCC_W-1:0]     occupancy_out;
  logic                 parity_err_out;

  modport master (
    output wren_in, wrptr_in, wrdata_in, empty_in, rdptr_in, ready_in,
    input  rdreq_out, valid_out, data_out, occupancy_out, parity_err_out
  );

  modport slave (
    input  wren_in, wrptr_in, wrdata_in, empty_in, rdptr_in, ready_in,
    output rdreq_out, valid_out, data_out, occupancy_out, parity_err_out
  );
endinterface

// File: rtl/kanagawa_fifo_show_ahead_reader.sv
// kanagawa_fifo_show_ahead_reader
// This block holds the FIFO storage RAM and the read-side skid buffer, and sits beside the pointer tracker.
// - RAM reads issued through rdreq_out return after RAM_LATENCY cycles.
// - Returned words land in a BUF_DEPTH-entry circular queue.
// - The queue presents a show-ahead valid/ready stream.
// - A read is only issued when a slot is guaranteed on return, so the queue cannot overflow.
// Optional build macro: KANAGAWA_FIFO_READER_PARITY_EN
// - When it is defined, the RAM stores an even-parity bit with each word.
// - The parity is checked as the word enters the queue and is reported at the head.
// RAM_LATENCY is legal for 1..3.
module kanagawa_fifo_show_ahead_reader #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 32,
  parameter int LOG_DEPTH   = $clog2(DEPTH),
  parameter int RAM_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  kanagawa_fifo_show_ahead_reader_if.slave bus
);
  localparam int BUF_DEPTH = RAM_LATENCY + 1;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W     = $clog2(BUF_DEPTH);
`ifdef KANAGAWA_FIFO_READER_PARITY_EN
  localparam int RAM_W     = WIDTH + 1;
`else
  localparam int RAM_W     = WIDTH;
`endif

  logic [RAM_W-1:0]       mem [DEPTH];
  logic [RAM_W-1:0]       wr_word;
  logic [LOG_DEPTH-1:0]   wr_addr;
  logic [LOG_DEPTH-1:0]   rd_addr;
  logic [RAM_W-1:0]       rd_pipe [RAM_LATENCY];
  logic [RAM_LATENCY-1:0] rd_vld;
  logic [WIDTH-1:0]       buf_data [BUF_DEPTH];
  logic [PTR_W-1:0]       head_q;
  logic [PTR_W-1:0]       tail_q;
  logic [OCC_W-1:0]       buf_cnt_q;
  logic [OCC_W-1:0]       occ_q;
  logic                   valid;
  logic                   pop;
  logic                   arrive;
  logic                   credit_ok;
  logic                   rdreq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_addr = bus.wrptr_in;
  assign rd_addr = bus.rdptr_in;
`ifdef KANAGAWA_FIFO_READER_PARITY_EN
  assign wr_word = {^bus.wrdata_in, bus.wrdata_in};
`else
  assign wr_word = bus.wrdata_in;
`endif

  assign valid  = (buf_cnt_q != '0);
  assign pop    = valid && bus.ready_in;
  assign arrive = rd_vld[RAM_LATENCY-1];

  // occ_q counts reads in flight plus buffered words.
  // A pop this cycle frees a slot in time for a word returning later.
  assign credit_ok = (occ_q != OCC_W'(BUF_DEPTH)) || pop;
  assign rdreq     = !rst && !bus.empty_in && credit_ok;

  // RAM storage plus a fixed-latency read pipeline.
  // A read and a write to the same address in one cycle return the old data.
  always_ff @(posedge clk) begin
    if (bus.wren_in) mem[wr_addr] <= wr_word;
    if (rdreq) rd_pipe[0] <= mem[rd_addr];
    for (int i = 1; i < RAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Tags that mark which read-pipeline stages hold a live word; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= '0;
    end else begin
      rd_vld[0] <= rdreq;
      for (int i = 1; i < RAM_LATENCY; i++) rd_vld[i] <= rd_vld[i-1];
    end
  end

  // Skid-buffer pointers and counters; an arrival and a pop can happen in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      buf_cnt_q <= '0;
      occ_q     <= '0;
    end else begin
      if (arrive) tail_q <= ptr_inc(tail_q);
      if (pop) head_q <= ptr_inc(head_q);
      buf_cnt_q <= buf_cnt_q + OCC_W'(arrive) - OCC_W'(pop);
      occ_q     <= occ_q + OCC_W'(rdreq) - OCC_W'(pop);
    end
  end

  // Skid-buffer data slots, written at the tail when a word returns from the RAM.
  always_ff @(posedge clk) begin
    if (arrive) buf_data[tail_q] <= rd_pipe[RAM_LATENCY-1][WIDTH-1:0];
  end

`ifdef KANAGAWA_FIFO_READER_PARITY_EN
  logic [BUF_DEPTH-1:0] buf_perr;

  // Per-entry parity verdict, captured when the word enters the buffer.
  always_ff @(posedge clk) begin
    if (arrive) buf_perr[tail_q] <= ^rd_pipe[RAM_LATENCY-1];
  end

  assign bus.parity_err_out = valid && buf_perr[head_q];
`else
  assign bus.parity_err_out = 1'b0;
`endif

  assign bus.rdreq_out     = rdreq;
  assign bus.valid_out     = valid;
  assign bus.data_out      = buf_data[head_q];
  assign bus.occupancy_out = occ_q;
endmodule
